// File: rtl/wdog_countdown.sv
// Watchdog countdown timer: prescaled countdown with early warning, expiry reset pulse and lock-out.
// Define WDOG_WINDOW_EN to add the WIN_VAL port and treat kicks above the window as violations.
module wdog_countdown #(
    parameter int CNT_W     = 32,
    parameter int PRE_W     = 8,
    parameter int RST_PULSE = 16
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             WDOG_EN,
    input  logic             KICK,
    input  logic [CNT_W-1:0] LOAD_VAL,
    input  logic [CNT_W-1:0] WARN_VAL,
`ifdef WDOG_WINDOW_EN
    input  logic [CNT_W-1:0] WIN_VAL,
`endif
    input  logic [PRE_W-1:0] PRESCALE,
    input  logic             IRQ_CLR,
    output logic [CNT_W-1:0] COUNT,
    output logic             WARN_IRQ,
    output logic             WDOG_RESET_REQ,
    output logic             TIMEOUT_STS,
    output logic             RUNNING
);

    localparam int PULSE_W = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        WARN   = 3'd2,
        EXPIRE = 3'd3,
        LOCK   = 3'd4
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     count_reg, count_next;
    logic [PRE_W-1:0]     pre_reg, pre_next;
    logic [PULSE_W-1:0]   pulse_cnt_reg, pulse_cnt_next;
    logic                 warn_irq_reg, warn_irq_next;
    logic                 timeout_reg, timeout_next;
    logic                 rst_req_reg, rst_req_next;
    logic                 running_reg, running_next;
    logic                 warn_set;
    logic                 timeout_set;
    logic                 tick;
    logic                 early_kick;

    assign tick = (pre_reg == PRESCALE);

`ifdef WDOG_WINDOW_EN
    assign early_kick = (count_reg > WIN_VAL);
`else
    assign early_kick = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        pre_next       = pre_reg;
        pulse_cnt_next = pulse_cnt_reg;
        warn_set       = 1'b0;
        timeout_set    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (WDOG_EN) begin
                    count_next = LOAD_VAL;
                    pre_next   = '0;
                    state_next = RUN;
                end
            end
            RUN, WARN: begin
                if (!WDOG_EN) begin
                    state_next = IDLE;
                end else if (KICK && early_kick) begin
                    state_next     = EXPIRE;
                    pulse_cnt_next = '0;
                    timeout_set    = 1'b1;
                end else if (KICK) begin
                    count_next = LOAD_VAL;
                    pre_next   = '0;
                    state_next = RUN;
                end else if (tick) begin
                    pre_next = '0;
                    if (count_reg == '0) begin
                        state_next     = EXPIRE;
                        pulse_cnt_next = '0;
                        timeout_set    = 1'b1;
                    end else begin
                        count_next = count_reg - CNT_W'(1);
                        // Warning fires only on the RUN->WARN transition, not on every tick in WARN
                        if ((state_reg == RUN) && (count_next <= WARN_VAL)) begin
                            state_next = WARN;
                            warn_set   = 1'b1;
                        end
                    end
                end else begin
                    pre_next = pre_reg + PRE_W'(1);
                end
            end
            EXPIRE: begin
                if (pulse_cnt_reg == PULSE_W'(RST_PULSE - 1)) begin
                    state_next = LOCK;
                end else begin
                    pulse_cnt_next = pulse_cnt_reg + PULSE_W'(1);
                end
            end
            LOCK: begin
                if (!WDOG_EN) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Set events take precedence over a coincident clear
    assign warn_irq_next = warn_set    | (warn_irq_reg & ~IRQ_CLR);
    assign timeout_next  = timeout_set | (timeout_reg  & ~IRQ_CLR);
    assign rst_req_next  = (state_next == EXPIRE);
    assign running_next  = (state_next == RUN) || (state_next == WARN);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            pre_reg       <= '0;
            pulse_cnt_reg <= '0;
            warn_irq_reg  <= 1'b0;
            timeout_reg   <= 1'b0;
            rst_req_reg   <= 1'b0;
            running_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            pre_reg       <= pre_next;
            pulse_cnt_reg <= pulse_cnt_next;
            warn_irq_reg  <= warn_irq_next;
            timeout_reg   <= timeout_next;
            rst_req_reg   <= rst_req_next;
            running_reg   <= running_next;
        end
    end

    assign COUNT          = count_reg;
    assign WARN_IRQ       = warn_irq_reg;
    assign WDOG_RESET_REQ = rst_req_reg;
    assign TIMEOUT_STS    = timeout_reg;
    assign RUNNING        = running_reg;

endmodule

// File: tb/tb_wdog_countdown.sv
// Self-checking bench for wdog_countdown: directed scenarios plus random traffic against a behavioural model.
module tb_wdog_countdown;

    localparam int CNT_W     = 32;
    localparam int PRE_W     = 8;
    localparam int RST_PULSE = 16;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_EXP  = 2;
    localparam int M_LOCK = 3;

    logic             CLK = 1'b0;
    logic             RESETn;
    logic             WDOG_EN;
    logic             KICK;
    logic [CNT_W-1:0] LOAD_VAL;
    logic [CNT_W-1:0] WARN_VAL;
`ifdef WDOG_WINDOW_EN
    logic [CNT_W-1:0] WIN_VAL;
`endif
    logic [PRE_W-1:0] PRESCALE;
    logic             IRQ_CLR;
    logic [CNT_W-1:0] COUNT;
    logic             WARN_IRQ;
    logic             WDOG_RESET_REQ;
    logic             TIMEOUT_STS;
    logic             RUNNING;

    wdog_countdown #(.CNT_W(CNT_W), .PRE_W(PRE_W), .RST_PULSE(RST_PULSE)) dut (
        .CLK            (CLK),
        .RESETn         (RESETn),
        .WDOG_EN        (WDOG_EN),
        .KICK           (KICK),
        .LOAD_VAL       (LOAD_VAL),
        .WARN_VAL       (WARN_VAL),
`ifdef WDOG_WINDOW_EN
        .WIN_VAL        (WIN_VAL),
`endif
        .PRESCALE       (PRESCALE),
        .IRQ_CLR        (IRQ_CLR),
        .COUNT          (COUNT),
        .WARN_IRQ       (WARN_IRQ),
        .WDOG_RESET_REQ (WDOG_RESET_REQ),
        .TIMEOUT_STS    (TIMEOUT_STS),
        .RUNNING        (RUNNING)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: mode, remaining count, cycles left until the next tick, reset-pulse cycles left
    int               m_mode;
    logic [CNT_W-1:0] m_count;
    int               m_wait;
    int               m_pulse_left;
    bit               m_warned;
    bit               m_warn_irq;
    bit               m_timeout;

    task automatic chk(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode       = M_IDLE;
        m_count      = '0;
        m_wait       = 0;
        m_pulse_left = 0;
        m_warned     = 1'b0;
        m_warn_irq   = 1'b0;
        m_timeout    = 1'b0;
    endtask

    task automatic start_expiry(inout bit set_t);
        m_mode       = M_EXP;
        m_pulse_left = RST_PULSE;
        set_t        = 1'b1;
    endtask

    task automatic model_edge();
        bit set_w = 1'b0;
        bit set_t = 1'b0;
        bit early = 1'b0;
`ifdef WDOG_WINDOW_EN
        early = (m_count > WIN_VAL);
`endif
        case (m_mode)
            M_IDLE: if (WDOG_EN) begin
                m_mode = M_RUN; m_count = LOAD_VAL; m_wait = int'(PRESCALE); m_warned = 1'b0;
            end
            M_RUN: begin
                if (!WDOG_EN) m_mode = M_IDLE;
                else if (KICK && early) start_expiry(set_t);
                else if (KICK) begin
                    m_count = LOAD_VAL; m_wait = int'(PRESCALE); m_warned = 1'b0;
                end else if (m_wait == 0) begin
                    m_wait = int'(PRESCALE);
                    if (m_count == 0) start_expiry(set_t);
                    else begin
                        m_count = m_count - 1;
                        if (!m_warned && m_count <= WARN_VAL) begin
                            m_warned = 1'b1; set_w = 1'b1;
                        end
                    end
                end else m_wait--;
            end
            M_EXP: begin
                m_pulse_left--;
                if (m_pulse_left == 0) m_mode = M_LOCK;
            end
            default: if (!WDOG_EN) m_mode = M_IDLE;
        endcase
        if (set_w) m_warn_irq = 1'b1; else if (IRQ_CLR) m_warn_irq = 1'b0;
        if (set_t) m_timeout  = 1'b1; else if (IRQ_CLR) m_timeout  = 1'b0;
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "_COUNT"},   COUNT,          m_count);
        chk({pfx, "_WARN"},    WARN_IRQ,       m_warn_irq);
        chk({pfx, "_RSTREQ"},  WDOG_RESET_REQ, m_mode == M_EXP);
        chk({pfx, "_TIMEOUT"}, TIMEOUT_STS,    m_timeout);
        chk({pfx, "_RUNNING"}, RUNNING,        m_mode == M_RUN);
    endtask

    task automatic step(input string pfx);
        @(posedge CLK);
        model_edge();
        #1;
        check_outputs(pfx);
        KICK    = 1'b0;
        IRQ_CLR = 1'b0;
    endtask

    // Advance until the model count reaches target while running; bounded
    task automatic run_to(input logic [CNT_W-1:0] target, input string pfx);
        int k = 0;
        while (!(m_mode == M_RUN && m_count == target) && k < 500) begin
            step(pfx);
            k++;
        end
        chk({pfx, "_REACH"}, (m_mode == M_RUN && m_count == target), 1);
    endtask

    int req_cycles;

    initial begin
        RESETn = 1'b0; WDOG_EN = 1'b0; KICK = 1'b0; IRQ_CLR = 1'b0;
        LOAD_VAL = '0; WARN_VAL = '0; PRESCALE = '0;
`ifdef WDOG_WINDOW_EN
        WIN_VAL = '1;
`endif
        model_reset();
        #12;
        check_outputs("RESET");
        @(negedge CLK);
        RESETn = 1'b1;

        // Timeout with no kicks
        LOAD_VAL = 10; WARN_VAL = 3; PRESCALE = 0; WDOG_EN = 1'b1;
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            step("T1");
            if (WDOG_RESET_REQ === 1'b1) req_cycles++;
        end
        chk("T1_PULSE_LEN", req_cycles, RST_PULSE);
        chk("T1_TIMEOUT_STS", TIMEOUT_STS, 1);
        chk("T1_WARN_IRQ", WARN_IRQ, 1);

        // LOCK ignores kicks; IRQ_CLR clears both sticky flags
        KICK = 1'b1; step("T5K");
        chk("T5_KICK_IGNORED", COUNT, 0);
        IRQ_CLR = 1'b1; step("T5C");
        chk("T5_WARN_CLR", WARN_IRQ, 0);
        chk("T5_TIMEOUT_CLR", TIMEOUT_STS, 0);
        WDOG_EN = 1'b0; step("T5D");

        // Kick reload with prescaler, then periodic kicks
        LOAD_VAL = 20; PRESCALE = 3; WDOG_EN = 1'b1;
        step("T2E");
        run_to(5, "T2W");
        KICK = 1'b1; step("T2K");
        chk("T2_RELOAD", COUNT, 20);
        req_cycles = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i % 40 == 39) KICK = 1'b1;
            step("T2P");
            if (WDOG_RESET_REQ !== 1'b0) req_cycles++;
        end
        chk("T2_NO_RESET", req_cycles, 0);

        // Kick coincident with the expiring tick
        WDOG_EN = 1'b0; step("T3D");
        LOAD_VAL = 4; PRESCALE = 0; WDOG_EN = 1'b1;
        step("T3E");
        run_to(0, "T3W");
        KICK = 1'b1; step("T3K");
        chk("T3_COUNT", COUNT, 4);
        chk("T3_NO_EXPIRE", WDOG_RESET_REQ, 0);
        chk("T3_RUNNING", RUNNING, 1);

        // Disable in WARN, then re-enable
        WDOG_EN = 1'b0; step("T4D");
        LOAD_VAL = 10; WARN_VAL = 3; WDOG_EN = 1'b1;
        step("T4E");
        run_to(2, "T4W");
        WDOG_EN = 1'b0; step("T4X");
        chk("T4_RUNNING", RUNNING, 0);
        chk("T4_HOLD", COUNT, 2);
        step("T4H");
        WDOG_EN = 1'b1; step("T4R");
        chk("T4_RELOAD", COUNT, 10);

`ifdef WDOG_WINDOW_EN
        // Early kick violates the window
        WDOG_EN = 1'b0; step("T6D");
        WIN_VAL = 5; LOAD_VAL = 10; WDOG_EN = 1'b1;
        step("T6E");
        run_to(8, "T6W");
        KICK = 1'b1; step("T6K");
        chk("T6_EARLY_EXPIRE", WDOG_RESET_REQ, 1);
        chk("T6_EARLY_TIMEOUT", TIMEOUT_STS, 1);
        for (int i = 0; i < RST_PULSE + 2; i++) step("T6P");
        WDOG_EN = 1'b0; step("T6L");
        WDOG_EN = 1'b1; step("T6R");
        run_to(4, "T6V");
        KICK = 1'b1; step("T6G");
        chk("T6_GOOD_KICK", COUNT, 10);
`endif

        // Random traffic against the model
        for (int s = 0; s < 20; s++) begin
            WDOG_EN = 1'b0;
            for (int k = 0; k < 40 && m_mode != M_IDLE; k++) step("RS");
            PRESCALE = PRE_W'($urandom_range(0, 3));
            WARN_VAL = $urandom_range(0, 45);
`ifdef WDOG_WINDOW_EN
            WIN_VAL  = $urandom_range(0, 40);
`endif
            WDOG_EN = 1'b1;
            for (int c = 0; c < 150; c++) begin
                LOAD_VAL = $urandom_range(0, 40);
                KICK     = ($urandom_range(0, 11) == 0);
                IRQ_CLR  = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 39) == 0) WDOG_EN = ~WDOG_EN;
                step("RND");
            end
        end

        // Asynchronous reset in the middle of the expiry pulse
        WDOG_EN = 1'b0;
        for (int k = 0; k < 40 && m_mode != M_IDLE; k++) step("AD");
        LOAD_VAL = 0; PRESCALE = 0; WDOG_EN = 1'b1;
        step("AE");
        for (int i = 0; i < 4; i++) step("AX");
        chk("ASYNC_PRE_REQ", WDOG_RESET_REQ, 1);
        RESETn = 1'b0;
        #1;
        model_reset();
        check_outputs("ASYNC_RST");
        @(negedge CLK);
        RESETn = 1'b1;
        step("AR");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wdog_countdown.md
Name: wdog_countdown

Overview:
Watchdog countdown timer. It sits directly downstream of the watchdog sequence state machine and consumes that block's enable level and kick strobe. It counts down a programmable timeout through a prescaler, raises an early-warning interrupt, and issues a fixed-width system reset request on expiry. Its status outputs feed the register read-back path.

Parameters:
CNT_W, 32, width of countdown counter, LOAD_VAL and WARN_VAL
PRE_W, 8, width of prescaler divide value
RST_PULSE, 16, number of CLK cycles WDOG_RESET_REQ is held high on expiry (must be >= 1)

Ports:
CLK  input  1  system clock; all state on rising edge
RESETn  input  1  asynchronous active-low reset
WDOG_EN  input  1  level enable from the sequence FSM; 1 = watchdog armed
KICK  input  1  single-cycle kick strobe from the kick-sequence FSM, active-high
LOAD_VAL  input  CNT_W  timeout reload value, sampled on enable entry and on each accepted kick
WARN_VAL  input  CNT_W  early-warning threshold
PRESCALE  input  PRE_W  tick divider; one tick every PRESCALE+1 cycles
IRQ_CLR  input  1  single-cycle strobe that clears WARN_IRQ and TIMEOUT_STS
COUNT  output  CNT_W  current count value
WARN_IRQ  output  1  sticky early-warning interrupt
WDOG_RESET_REQ  output  1  reset request pulse, RST_PULSE cycles wide
TIMEOUT_STS  output  1  sticky flag: an expiry has occurred
RUNNING  output  1  1 in RUN or WARN states

Behaviour:
- Reset (RESETn=0, asynchronous): state=IDLE, COUNT=0, prescaler=0, WARN_IRQ=0, WDOG_RESET_REQ=0, TIMEOUT_STS=0, RUNNING=0.
- States: IDLE, RUN, WARN, EXPIRE, LOCK.
- IDLE:
  - WDOG_EN=1 -> next cycle COUNT=LOAD_VAL, prescaler=0, state=RUN.
- Tick: prescaler counts 0..PRESCALE; tick=1 in the cycle the prescaler equals PRESCALE, and it wraps to 0 on the same edge. PRESCALE=0 gives a tick every cycle. The prescaler runs only in RUN and WARN.
- RUN/WARN, evaluated per cycle in priority order:
  1. WDOG_EN=0 -> IDLE; COUNT holds; RUNNING=0 the next cycle.
  2. KICK=1 -> COUNT=LOAD_VAL, prescaler=0, state=RUN. WARN_IRQ is not cleared.
  3. Tick with COUNT==0 -> EXPIRE.
  4. Tick otherwise -> COUNT=COUNT-1. If the new COUNT <= WARN_VAL and state is RUN, go to WARN and set WARN_IRQ.
- Kick on the same cycle as an expiring tick: the kick wins and no expiry occurs.
- LOAD_VAL=0: expiry on the first tick after entry or kick.
- WARN_VAL >= LOAD_VAL: WARN is entered on the first tick.
- EXPIRE:
  - WDOG_RESET_REQ=1 for exactly RST_PULSE cycles, counted by an internal counter.
  - TIMEOUT_STS set on entry.
  - KICK and WDOG_EN are ignored.
  - After RST_PULSE cycles -> LOCK.
- LOCK: WDOG_RESET_REQ=0. WDOG_EN=0 -> IDLE. Kicks are ignored.
- IRQ_CLR: clears WARN_IRQ and TIMEOUT_STS the next cycle. A set event in the same cycle wins over the clear.
- COUNT never wraps below 0.
- All outputs are registered; the latency from KICK to the COUNT reload is 1 cycle.
- Reset mid-EXPIRE aborts the pulse immediately (asynchronous).

Optional Feature:
Macro WDOG_WINDOW_EN.
- Defined:
  - Adds input port WIN_VAL [CNT_W].
  - A kick in RUN/WARN with COUNT > WIN_VAL is an early kick. It is treated as a violation and forces EXPIRE on the next cycle, the same as a timeout; TIMEOUT_STS is set.
  - A kick with COUNT <= WIN_VAL behaves normally.
- Not defined: no WIN_VAL port, and every kick in RUN/WARN is accepted.

Test Plan:
1. Timeout: LOAD_VAL=10, WARN_VAL=3, PRESCALE=0, raise WDOG_EN, no kicks -> RUNNING=1; WARN_IRQ=1 when COUNT reaches 3; WDOG_RESET_REQ high for 16 cycles after COUNT=0 plus one tick; TIMEOUT_STS=1; state LOCK.
2. Kick reload: LOAD_VAL=20, PRESCALE=3, KICK when COUNT=5 -> next cycle COUNT=20; no reset request; with kicks every 40 cycles, WDOG_RESET_REQ never asserts over 1000 cycles.
3. Kick/expiry collision: LOAD_VAL=4, PRESCALE=0, KICK on the exact cycle of the COUNT==0 tick -> COUNT=4, no EXPIRE.
4. Disable/re-enable: drop WDOG_EN in WARN at COUNT=2 -> IDLE, RUNNING=0, COUNT holds 2; re-enable -> COUNT=LOAD_VAL.
5. IRQ_CLR: assert IRQ_CLR in LOCK -> WARN_IRQ=0 and TIMEOUT_STS=0; KICK in LOCK -> no effect.
6. WDOG_WINDOW_EN build: WIN_VAL=5, LOAD_VAL=10, KICK at COUNT=8 -> EXPIRE, WDOG_RESET_REQ pulse; KICK at COUNT=4 -> COUNT=10.
